// File: rtl/wb_regfile_unit_pkg.sv
// rtl/wb_regfile_unit_pkg.sv - shared constants and types for the write-back register file unit
package wb_regfile_unit_pkg;

   localparam int unsigned REG_ZERO    = 0;
   localparam int unsigned REG_RA      = 31;
   localparam int unsigned LINK_OFFSET = 4;

   typedef logic [4:0]  reg_idx_t;
   typedef logic [31:0] word_t;

   // Write-back value mux: link address wins over load data, load data over ALU result.
   function automatic word_t wb_value(input logic jal, input logic mem_to_reg,
                                      input word_t pc, input word_t link_off,
                                      input word_t dout, input word_t result);
      if (jal)
         return pc + link_off;
      else if (mem_to_reg)
         return dout;
      else
         return result;
   endfunction

endpackage

// File: rtl/wb_regfile_unit_gpr_file_32x32.sv
// rtl/wb_regfile_unit_gpr_file_32x32.sv - 32x32 GPR array, one write port, two raw read ports
module gpr_file_32x32
   import wb_regfile_unit_pkg::*;
(
   input  logic     Clk,
   input  logic     Rst_n,
   input  logic     We,
   input  reg_idx_t Waddr,
   input  word_t    Wdata,
   input  reg_idx_t Ra,
   input  reg_idx_t Rb,
   output word_t    RdA,
   output word_t    RdB
);

   word_t regs [0:31];

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         for (int i = 0; i < 32; i++)
            regs[i] <= '0;
      end else if (We && (Waddr != reg_idx_t'(REG_ZERO))) begin
         regs[Waddr] <= Wdata;
      end
   end

   // Register 0 reads as zero regardless of what the array holds.
   assign RdA = (Ra == reg_idx_t'(REG_ZERO)) ? '0 : regs[Ra];
   assign RdB = (Rb == reg_idx_t'(REG_ZERO)) ? '0 : regs[Rb];

endmodule

// File: rtl/wb_regfile_unit.sv
// rtl/wb_regfile_unit.sv - write-back stage: GPR/HI/LO commit with write-first bypassed reads
module wb_regfile_unit
   import wb_regfile_unit_pkg::*;
#(
   parameter int unsigned LINK_OFFSET = wb_regfile_unit_pkg::LINK_OFFSET,
   parameter int unsigned RA_REG      = wb_regfile_unit_pkg::REG_RA
)(
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic        MemtoReg,
   input  logic        RegWr,
   input  logic        Of,
   input  logic        Jal,
   input  logic        MTLO,
   input  logic        MTHI,
   input  logic [31:0] Dout,
   input  logic [31:0] Result,
   input  logic [4:0]  Rw,
   input  logic [31:0] PC,
   input  logic [31:0] LoRe,
   input  logic [31:0] HiRe,
   input  logic [4:0]  Ra,
   input  logic [4:0]  Rb,
   output logic [31:0] BusA,
   output logic [31:0] BusB,
   output logic [31:0] LoOut,
   output logic [31:0] HiOut,
   output logic        OvfSticky,
   output logic [31:0] CommitCnt
);

   localparam word_t    LINK_OFF = word_t'(LINK_OFFSET);
   localparam reg_idx_t RA_IDX   = reg_idx_t'(RA_REG);

   reg_idx_t dest;
   word_t    wval;
   logic     wr_req;
   logic     gpr_we;
   logic     lo_we;
   logic     hi_we;
   word_t    raw_a;
   word_t    raw_b;
   word_t    lo_q;
   word_t    hi_q;
   word_t    commit_cnt;
   logic     ovf_q;

   assign dest   = Jal ? RA_IDX : Rw;
   assign wval   = wb_value(Jal, MemtoReg, PC, LINK_OFF, Dout, Result);
   assign wr_req = RegWr | Jal;
   // Reset gates every enable so a write presented during reset neither commits nor bypasses.
   assign gpr_we = wr_req & ~Of & (dest != reg_idx_t'(REG_ZERO)) & Rst_n;
   assign lo_we  = MTLO & Rst_n;
   assign hi_we  = MTHI & Rst_n;

   gpr_file_32x32 u_gpr (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .We    (gpr_we),
      .Waddr (dest),
      .Wdata (wval),
      .Ra    (Ra),
      .Rb    (Rb),
      .RdA   (raw_a),
      .RdB   (raw_b)
   );

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         lo_q       <= '0;
         hi_q       <= '0;
         commit_cnt <= '0;
         ovf_q      <= 1'b0;
      end else begin
         if (lo_we)
            lo_q <= LoRe;
         if (hi_we)
            hi_q <= HiRe;
         if (gpr_we)
            commit_cnt <= commit_cnt + 32'd1;
         if (wr_req && Of)
            ovf_q <= 1'b1;
      end
   end

   always_comb begin
      BusA = raw_a;
      BusB = raw_b;
      if (Ra == reg_idx_t'(REG_ZERO))
         BusA = '0;
      else if (gpr_we && (Ra == dest))
         BusA = wval;
      if (Rb == reg_idx_t'(REG_ZERO))
         BusB = '0;
      else if (gpr_we && (Rb == dest))
         BusB = wval;
   end

   assign LoOut     = lo_we ? LoRe : lo_q;
   assign HiOut     = hi_we ? HiRe : hi_q;
   assign OvfSticky = ovf_q;
   assign CommitCnt = commit_cnt;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// tb/tb_wb_regfile_unit.sv - directed self-checking bench for wb_regfile_unit
module tb_wb_regfile_unit;

   logic        Clk = 1'b0;
   logic        Rst_n, MemtoReg, RegWr, Of, Jal, MTLO, MTHI;
   logic [31:0] Dout, Result, PC, LoRe, HiRe;
   logic [4:0]  Rw, Ra, Rb;
   logic [31:0] BusA, BusB, LoOut, HiOut, CommitCnt;
   logic        OvfSticky;

   int errors = 0;
   int checks = 0;

   wb_regfile_unit #(.LINK_OFFSET(4), .RA_REG(31)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .MemtoReg(MemtoReg), .RegWr(RegWr), .Of(Of), .Jal(Jal),
      .MTLO(MTLO), .MTHI(MTHI), .Dout(Dout), .Result(Result), .Rw(Rw), .PC(PC),
      .LoRe(LoRe), .HiRe(HiRe), .Ra(Ra), .Rb(Rb), .BusA(BusA), .BusB(BusB),
      .LoOut(LoOut), .HiOut(HiOut), .OvfSticky(OvfSticky), .CommitCnt(CommitCnt)
   );

   always #5 Clk = ~Clk;

   task automatic idle_inputs();
      MemtoReg = 0; RegWr = 0; Of = 0; Jal = 0; MTLO = 0; MTHI = 0;
      Dout = '0; Result = '0; PC = '0; LoRe = '0; HiRe = '0; Rw = '0;
   endtask

   task automatic test_reset();
      Rst_n = 0; idle_inputs(); Ra = 5; Rb = 31;
      repeat (2) @(posedge Clk);
      @(negedge Clk); Rst_n = 1; #1;
      checks++; if (BusA !== 32'h0) begin errors++; $display("FAIL reset_busa got %h exp %h", BusA, 32'h0); end
      checks++; if (BusB !== 32'h0) begin errors++; $display("FAIL reset_busb got %h exp %h", BusB, 32'h0); end
      checks++; if (CommitCnt !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp %h", CommitCnt, 32'h0); end
      checks++; if (OvfSticky !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", OvfSticky); end
      checks++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h exp 0/0", HiOut, LoOut); end
   endtask

   task automatic test_bypass();
      @(negedge Clk); RegWr = 1; Rw = 5; Result = 32'h1234; Ra = 5; Rb = 6; #1;
      checks++; if (BusA !== 32'h1234) begin errors++; $display("FAIL bypass_busa got %h exp %h", BusA, 32'h1234); end
      checks++; if (BusB !== 32'h0) begin errors++; $display("FAIL bypass_other got %h exp %h", BusB, 32'h0); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (BusA !== 32'h1234) begin errors++; $display("FAIL array_busa got %h exp %h", BusA, 32'h1234); end
      checks++; if (CommitCnt !== 32'd1) begin errors++; $display("FAIL cnt_after_write got %h exp %h", CommitCnt, 32'd1); end
   endtask

   task automatic test_memtoreg();
      @(negedge Clk); MemtoReg = 1; RegWr = 1; Dout = 32'hDEADBEEF; Result = 32'h5; Rw = 0; Ra = 0; Rb = 0; #1;
      checks++; if (BusA !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp %h", BusA, 32'h0); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (CommitCnt !== 32'd1) begin errors++; $display("FAIL r0_cnt got %h exp %h", CommitCnt, 32'd1); end
      @(negedge Clk); MemtoReg = 1; RegWr = 1; Dout = 32'hDEADBEEF; Result = 32'h5; Rw = 9; Rb = 9; #1;
      checks++; if (BusB !== 32'hDEADBEEF) begin errors++; $display("FAIL load_bypass got %h exp %h", BusB, 32'hDEADBEEF); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (BusB !== 32'hDEADBEEF) begin errors++; $display("FAIL load_array got %h exp %h", BusB, 32'hDEADBEEF); end
      checks++; if (CommitCnt !== 32'd2) begin errors++; $display("FAIL load_cnt got %h exp %h", CommitCnt, 32'd2); end
   endtask

   task automatic test_jal();
      @(negedge Clk); Jal = 1; PC = 32'h00400010; Rw = 7; Result = 32'h77; Ra = 31; Rb = 7; #1;
      checks++; if (BusA !== 32'h00400014) begin errors++; $display("FAIL jal_bypass got %h exp %h", BusA, 32'h00400014); end
      checks++; if (BusB !== 32'h0) begin errors++; $display("FAIL jal_rw_bypass got %h exp %h", BusB, 32'h0); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (BusA !== 32'h00400014) begin errors++; $display("FAIL jal_ra got %h exp %h", BusA, 32'h00400014); end
      checks++; if (BusB !== 32'h0) begin errors++; $display("FAIL jal_r7 got %h exp %h", BusB, 32'h0); end
      checks++; if (CommitCnt !== 32'd3) begin errors++; $display("FAIL jal_cnt got %h exp %h", CommitCnt, 32'd3); end
   endtask

   task automatic test_overflow();
      @(negedge Clk); RegWr = 1; Of = 1; Rw = 8; Result = 32'hFF; Ra = 8;
      MTHI = 1; MTLO = 1; HiRe = 32'hA; LoRe = 32'hB; #1;
      checks++; if (BusA !== 32'h0) begin errors++; $display("FAIL ovf_no_bypass got %h exp %h", BusA, 32'h0); end
      checks++; if (HiOut !== 32'hA) begin errors++; $display("FAIL hi_bypass got %h exp %h", HiOut, 32'hA); end
      checks++; if (LoOut !== 32'hB) begin errors++; $display("FAIL lo_bypass got %h exp %h", LoOut, 32'hB); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (BusA !== 32'h0) begin errors++; $display("FAIL ovf_r8 got %h exp %h", BusA, 32'h0); end
      checks++; if (OvfSticky !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", OvfSticky); end
      checks++; if (CommitCnt !== 32'd3) begin errors++; $display("FAIL ovf_cnt got %h exp %h", CommitCnt, 32'd3); end
      checks++; if (HiOut !== 32'hA || LoOut !== 32'hB) begin errors++; $display("FAIL hilo_reg got %h/%h exp a/b", HiOut, LoOut); end
      @(posedge Clk); #1;
      checks++; if (OvfSticky !== 1'b1) begin errors++; $display("FAIL ovf_hold got %b exp 1", OvfSticky); end
      @(negedge Clk); MTHI = 1; HiRe = 32'h55; LoRe = 32'h66; #1;
      checks++; if (HiOut !== 32'h55 || LoOut !== 32'hB) begin errors++; $display("FAIL mthi_only_byp got %h/%h exp 55/b", HiOut, LoOut); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (HiOut !== 32'h55 || LoOut !== 32'hB) begin errors++; $display("FAIL mthi_only got %h/%h exp 55/b", HiOut, LoOut); end
   endtask

   task automatic test_back_to_back();
      @(negedge Clk); RegWr = 1; Rw = 10; Result = 32'h1; Ra = 10; Rb = 5;
      @(posedge Clk); #1; Result = 32'h2; #1;
      checks++; if (BusA !== 32'h2) begin errors++; $display("FAIL b2b_bypass got %h exp %h", BusA, 32'h2); end
      checks++; if (BusB !== 32'h1234) begin errors++; $display("FAIL b2b_other got %h exp %h", BusB, 32'h1234); end
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (BusA !== 32'h2) begin errors++; $display("FAIL b2b_array got %h exp %h", BusA, 32'h2); end
      checks++; if (CommitCnt !== 32'd5) begin errors++; $display("FAIL b2b_cnt got %h exp %h", CommitCnt, 32'd5); end
   endtask

   task automatic test_wrap();
      @(negedge Clk);
      force dut.commit_cnt = 32'hFFFF_FFFF;
      #1; release dut.commit_cnt; #1;
      checks++; if (CommitCnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h exp %h", CommitCnt, 32'hFFFF_FFFF); end
      RegWr = 1; Rw = 12; Result = 32'h77;
      @(posedge Clk); #1; idle_inputs(); #1;
      checks++; if (CommitCnt !== 32'h0) begin errors++; $display("FAIL wrap_cnt got %h exp %h", CommitCnt, 32'h0); end
   endtask

   task automatic test_reset_dominates();
      @(negedge Clk); Rst_n = 0; RegWr = 1; Rw = 5; Result = 32'h999; Ra = 5; Rb = 12;
      MTHI = 1; HiRe = 32'h77; #1;
      checks++; if (BusA !== 32'h1234) begin errors++; $display("FAIL rst_no_bypass got %h exp %h", BusA, 32'h1234); end
      checks++; if (HiOut !== 32'h55) begin errors++; $display("FAIL rst_hi_no_bypass got %h exp %h", HiOut, 32'h55); end
      @(posedge Clk); #1; Rst_n = 1; idle_inputs(); #1;
      checks++; if (BusA !== 32'h0 || BusB !== 32'h0) begin errors++; $display("FAIL rst_gpr got %h/%h exp 0/0", BusA, BusB); end
      checks++; if (CommitCnt !== 32'h0) begin errors++; $display("FAIL rst_cnt got %h exp %h", CommitCnt, 32'h0); end
      checks++; if (OvfSticky !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", OvfSticky); end
      checks++; if (HiOut !== 32'h0 || LoOut !== 32'h0) begin errors++; $display("FAIL rst_hilo got %h/%h exp 0/0", HiOut, LoOut); end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_memtoreg();
      test_jal();
      test_overflow();
      test_back_to_back();
      test_wrap();
      test_reset_dominates();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
